mlp_batch_sequencer: RTL and testbench

//   Sequences the MLP inference core over a batch of stored test images: steps the image

---
 rtl/mlp_batch_sequencer_if.sv | 31 +++
 rtl/mlp_batch_sequencer.sv | 144 ++++++++++++++
 tb/tb_mlp_batch_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_batch_sequencer_if.sv
// Handshake bundle between the batch sequencer, the switch/key inputs,
// the MLP core and the LCD word. slave = sequencer side, master = env side.
interface mlp_batch_sequencer_if #(
  parameter int IDX_W   = 8,
  parameter int CLASS_W = 4,
  parameter int LCD_W   = 128
);
  logic [IDX_W-1:0]   sample_count;
  logic               go;
  logic [IDX_W-1:0]   img_addr;
  logic               mlp_start;
  logic               mlp_done;
  logic [CLASS_W-1:0] mlp_class;
  logic [LCD_W-1:0]   lcd_output;
  logic [IDX_W-1:0]   processed;
  logic               busy;
  logic               batch_done;
  logic               timeout_err;

  modport slave (
    input  sample_count, go, mlp_done, mlp_class,
    output img_addr, mlp_start, lcd_output,
    output processed, busy, batch_done, timeout_err
  );

  modport master (
    output sample_count, go, mlp_done, mlp_class,
    input  img_addr, mlp_start, lcd_output,
    input  processed, busy, batch_done, timeout_err
  );
endinterface

// File: rtl/mlp_batch_sequencer.sv
// Steps the MLP core over a batch of stored images and packs each 4-bit
// class into the LCD word. Ports: s_axi_aclk, s_axi_aresetn, io_seq (slave).
module mlp_batch_sequencer #(
  parameter int MAX_SAMPLES = 32,
  parameter int CLASS_W     = 4,
  parameter int IDX_W       = 8,
  parameter int ROM_LATENCY = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  mlp_batch_sequencer_if.slave  io_seq
);

  localparam int LCD_W = CLASS_W * MAX_SAMPLES;
  localparam int LAT_W = $clog2(ROM_LATENCY + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_go;
  logic [IDX_W-1:0]   r_n;
  logic [IDX_W-1:0]   r_addr;
  logic [IDX_W-1:0]   r_proc;
  logic [LCD_W-1:0]   r_lcd;
  logic               r_terr;
  logic [CLASS_W-1:0] r_class;
  logic [LAT_W-1:0]   r_lat;
  logic [TO_W-1:0]    r_wcnt;

  logic               w_accept;
  logic [IDX_W-1:0]   w_n;
  logic [IDX_W-1:0]   w_proc_inc;
  logic               w_last;
  logic               w_tmo;
  logic               w_lat_end;

  always_comb begin
    w_accept   = 1'b0;
    w_n        = io_seq.sample_count;
    w_proc_inc = r_proc + IDX_W'(1);
    w_last     = (w_proc_inc == r_n);
    w_tmo      = (r_wcnt == TO_W'(TIMEOUT - 1));
    w_lat_end  = (r_lat == LAT_W'(ROM_LATENCY - 1));
    w_next     = r_state;
    if (io_seq.sample_count > IDX_W'(MAX_SAMPLES))
      w_n = IDX_W'(MAX_SAMPLES);
    // go is only honoured between batches
    if (io_seq.go && !r_go &&
        (r_state == S_IDLE || r_state == S_DONE))
      w_accept = 1'b1;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)
          w_next = (w_n == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (w_lat_end)
          w_next = S_START;
      end
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (io_seq.mlp_done || w_tmo)
          w_next = S_STORE;
      end
      S_STORE: w_next = w_last ? S_DONE : S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_go    <= 1'b0;
      r_n     <= '0;
      r_addr  <= '0;
      r_proc  <= '0;
      r_lcd   <= '0;
      r_terr  <= 1'b0;
      r_class <= '0;
      r_lat   <= '0;
      r_wcnt  <= '0;
    end else begin
      r_go <= io_seq.go;
      if (w_accept) begin
        r_n    <= w_n;
        r_addr <= '0;
        r_proc <= '0;
        r_lcd  <= '0;
        r_terr <= 1'b0;
        r_lat  <= '0;
      end
      unique case (r_state)
        S_LOAD: r_lat <= r_lat + LAT_W'(1);
        S_START: r_wcnt <= '0;
        S_WAIT: begin
          r_wcnt <= r_wcnt + TO_W'(1);
          if (io_seq.mlp_done) begin
            r_class <= io_seq.mlp_class;
          end else if (w_tmo) begin
            // a lost sample is reported as class F
            r_class <= '1;
            r_terr  <= 1'b1;
          end
        end
        S_STORE: begin
          for (int i = 0; i < MAX_SAMPLES; i++)
            if (r_addr == IDX_W'(i))
              r_lcd[i*CLASS_W +: CLASS_W] <= r_class;
          r_proc <= w_proc_inc;
          r_lat  <= '0;
          if (!w_last)
            r_addr <= r_addr + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign io_seq.img_addr    = r_addr;
  assign io_seq.mlp_start   = (r_state == S_START);
  assign io_seq.lcd_output  = r_lcd;
  assign io_seq.processed   = r_proc;
  assign io_seq.busy        = (r_state != S_IDLE) &&
                              (r_state != S_DONE);
  assign io_seq.batch_done  = (r_state == S_DONE);
  assign io_seq.timeout_err = r_terr;

endmodule

// File: tb/tb_mlp_batch_sequencer.sv
// Directed bench for mlp_batch_sequencer with a behavioural core model
// and a per-cycle result scoreboard.
module tb_mlp_batch_sequencer;

  localparam int MAXS = 32;
  localparam int CW   = 4;
  localparam int IW   = 8;
  localparam int TMO  = 100;
  localparam int DLY  = 50;

  localparam logic [127:0] L_MOD10 = 128'h10987654321098765432109876543210;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mlp_batch_sequencer_if #(.IDX_W(IW), .CLASS_W(CW), .LCD_W(128)) ifc();

  mlp_batch_sequencer #(
    .MAX_SAMPLES(MAXS),
    .CLASS_W(CW),
    .IDX_W(IW),
    .ROM_LATENCY(2),
    .TIMEOUT(TMO)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(rst_n),
    .io_seq(ifc)
  );

  int       checks = 0;
  int       errors = 0;
  logic [3:0] exp_slot [MAXS];
  int       exp_n = 0;
  int       skip_idx = -1;
  bit       early = 1'b0;
  bit       inj_done = 1'b0;
  int       starts = 0;
  int       start_addr [64];
  bit       pend = 1'b0;
  int       cnt = 0;
  logic [3:0] pcls = '0;
  bit       chk_en = 1'b0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Core model: classifies the image at img_addr as (addr mod 10),
  // DLY cycles after its start pulse; can skip a sample or answer early.
  always @(negedge clk) begin
    ifc.mlp_done = inj_done;
    if (inj_done) ifc.mlp_class = 4'h9;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          ifc.mlp_done  = 1'b1;
          ifc.mlp_class = pcls;
          pend = 1'b0;
        end
      end
      if (ifc.mlp_start) begin
        if (starts < 64) start_addr[starts] = int'(ifc.img_addr);
        starts++;
        if (early) begin
          ifc.mlp_done  = 1'b1;
          ifc.mlp_class = 4'h7;
        end
        if (int'(ifc.img_addr) != skip_idx) begin
          pend = 1'b1;
          cnt  = DLY;
          pcls = 4'(ifc.img_addr % 10);
        end
      end
    end
  end

  // Per-cycle scoreboard: completed slots hold the model class, the rest 0.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < MAXS; i++)
        if (i < int'(ifc.processed)) w[i*4 +: 4] = exp_slot[i];
      chk("lcd_cycle", ifc.lcd_output, w);
      chk("busy_and_done", 128'(ifc.busy & ifc.batch_done), 128'd0);
      chk("start_idle", 128'(ifc.mlp_start & ~ifc.busy), 128'd0);
      if (ifc.busy)
        chk("addr_range", 128'(int'(ifc.img_addr) < exp_n), 128'd1);
      chk("proc_range", 128'(int'(ifc.processed) <= exp_n), 128'd1);
    end
  end

  task automatic setup(int sc, int sk, bit e);
    chk_en   = 1'b0;
    skip_idx = sk;
    early    = e;
    starts   = 0;
    exp_n    = (sc > MAXS) ? MAXS : sc;
    for (int i = 0; i < MAXS; i++)
      exp_slot[i] = (i == sk) ? 4'hF : 4'(i % 10);
    ifc.sample_count = IW'(sc);
  endtask

  task automatic go_pulse();
    @(negedge clk) ifc.go = 1'b1;
    @(negedge clk) ifc.go = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!ifc.batch_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_finished"}, 128'(ifc.batch_done), 128'd1);
  endtask

  task automatic wait_starts(string nm, int k);
    int n = 0;
    while (starts < k && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_starts_seen"}, 128'(starts >= k), 128'd1);
  endtask

  task automatic fin(string nm, bit terr, logic [127:0] lit);
    logic [127:0] e;
    bit ok;
    e  = '0;
    ok = 1'b1;
    for (int i = 0; i < exp_n; i++) e[i*4 +: 4] = exp_slot[i];
    chk({nm, "_lcd"}, ifc.lcd_output, e);
    chk({nm, "_lcd_lit"}, ifc.lcd_output, lit);
    chk({nm, "_processed"}, 128'(ifc.processed), 128'(exp_n));
    chk({nm, "_timeout_err"}, 128'(ifc.timeout_err), 128'(terr));
    chk({nm, "_start_count"}, 128'(starts), 128'(exp_n));
    chk({nm, "_busy"}, 128'(ifc.busy), 128'd0);
    for (int k = 0; k < starts && k < 64; k++)
      if (start_addr[k] != k) ok = 1'b0;
    chk({nm, "_addr_seq"}, 128'(ok), 128'd1);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_ctl"}, 128'({ifc.img_addr, ifc.mlp_start, ifc.processed,
         ifc.busy, ifc.batch_done, ifc.timeout_err}), 128'd0);
    chk({nm, "_lcd"}, ifc.lcd_output, 128'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    ifc.go = 1'b0;
    ifc.sample_count = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_reset");

    // stray done while idle
    setup(0, -1, 1'b0);
    chk_en = 1'b1;
    @(negedge clk) inj_done = 1'b1;
    @(negedge clk) inj_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("idle_done");

    // full batch of 32
    setup(32, -1, 1'b0);
    go_pulse();
    wait_done("t1");
    fin("t1", 1'b0, L_MOD10);

    // empty batch
    setup(0, -1, 1'b0);
    go_pulse();
    chk("t2_done_next", 128'(ifc.batch_done), 128'd1);
    repeat (5) @(negedge clk);
    fin("t2", 1'b0, 128'd0);

    // oversized request clamps to 32
    setup(200, -1, 1'b0);
    go_pulse();
    wait_done("t3");
    fin("t3", 1'b0, L_MOD10);

    // sample 3 never answered
    setup(8, 3, 1'b0);
    go_pulse();
    wait_done("t4");
    fin("t4", 1'b1, 128'h7654F210);

    // go re-pulsed mid-batch, early done alongside each start
    setup(5, -1, 1'b1);
    go_pulse();
    wait_starts("t5", 1);
    @(negedge clk) ifc.go = 1'b1;
    @(negedge clk) ifc.go = 1'b0;
    repeat (20) @(negedge clk);
    @(negedge clk) ifc.go = 1'b1;
    @(negedge clk) ifc.go = 1'b0;
    wait_done("t5");
    fin("t5", 1'b0, 128'h43210);

    // reset during WAIT of sample 10
    setup(32, -1, 1'b0);
    go_pulse();
    wait_starts("t6", 11);
    chk("t6_addr10", 128'(start_addr[10]), 128'd10);
    repeat (10) @(negedge clk);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_zero("t6_abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("t6_released");
    setup(32, -1, 1'b0);
    go_pulse();
    wait_done("t6");
    fin("t6", 1'b0, L_MOD10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
